// File: rtl/ooo_fetch_queue_pkg.sv
// Shared types for the instruction fetch queue: the buffered {instruction, pc} entry and PC helpers.
// Pure declarations; no timing or backpressure of its own.
package ooo_fetch_pkg;

    localparam int FQ_DATA_W  = 32;
    localparam int FQ_ADDR_W  = 32;
    localparam int FQ_DEPTH   = 8;
    localparam int INST_BYTES = 4;

    typedef struct packed {
        logic [FQ_DATA_W-1:0] inst;
        logic [FQ_ADDR_W-1:0] pc;
    } fetch_entry_t;

    function automatic logic [FQ_ADDR_W-1:0] align_pc(input logic [FQ_ADDR_W-1:0] addr);
        return {addr[FQ_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ooo_fetch_queue_if.sv
// Fetch-queue bundle: instruction-memory request/response channel plus the execution-unit side.
// master = fetch queue, slave = its environment (memory + execution unit).
interface ooo_fetch_queue_if
    import ooo_fetch_pkg::*;
#(
    parameter int DATA_WIDTH = FQ_DATA_W,
    parameter int ADDR_WIDTH = FQ_ADDR_W
);

    logic                  imem_req_valid;
    logic [ADDR_WIDTH-1:0] imem_req_addr;
    logic                  imem_req_ready;
    logic                  imem_resp_valid;
    logic [DATA_WIDTH-1:0] imem_resp_data;
    logic [DATA_WIDTH-1:0] instruction;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  inst_valid;
    logic                  fetch_stall;
    logic                  branch_taken;
    logic [ADDR_WIDTH-1:0] branch_target;

    modport master (
        output imem_req_valid, imem_req_addr, instruction, pc, inst_valid,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
               fetch_stall, branch_taken, branch_target
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instruction, pc, inst_valid,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
               fetch_stall, branch_taken, branch_target
    );

endinterface

// File: rtl/ooo_fetch_queue_fifo.sv
// Single-clock FIFO with synchronous flush; head is combinational from storage (push visible next cycle).
// No internal backpressure: push when full and pop when empty are ignored, callers must respect full/empty.
module ooo_sync_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = logic,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  T                 push_dat,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output T                 head,
    output logic             full,
    output logic             empty
);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // Storage carries no reset; validity is tracked purely by count.
    always_ff @(posedge clk) begin
        if (push_ok && !rst && !flush) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/ooo_fetch_queue.sv
// In-order fetch front-end: issues sequential PCs, buffers responses, presents head; push->head 1 cycle.
// Backpressure: requests held while count+outstanding==DEPTH or memory not ready; head held under fetch_stall.
module ooo_fetch_queue
    import ooo_fetch_pkg::*;
#(
    parameter int                    DEPTH      = FQ_DEPTH,
    parameter int                    DATA_WIDTH = FQ_DATA_W,
    parameter int                    ADDR_WIDTH = FQ_ADDR_W,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_1000
) (
    input  logic clk,
    input  logic rst,
    ooo_fetch_queue_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] resp_pc;
    logic [CNT_W-1:0]      outstanding;
    logic [CNT_W-1:0]      drop_cnt;
    logic [CNT_W-1:0]      count;
    logic [CNT_W:0]        inflight;
    logic                  credit_ok;
    logic                  req_fire;
    logic                  resp_fire;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [ADDR_WIDTH-1:0] target_pc;
    fetch_entry_t          push_entry;
    fetch_entry_t          head;

    // Queue occupancy plus in-flight requests is the credit pool, so a response always finds a free slot.
    assign inflight  = (CNT_W+1)'(count) + (CNT_W+1)'(outstanding);
    assign credit_ok = inflight < (CNT_W+1)'(DEPTH);

    assign bus.imem_req_valid = !rst && !bus.branch_taken && credit_ok;
    assign bus.imem_req_addr  = fetch_pc;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

    assign resp_fire = !rst && bus.imem_resp_valid && (outstanding != '0);
    assign push      = resp_fire && (drop_cnt == '0) && !bus.branch_taken && !full;

    assign bus.inst_valid  = !rst && !empty;
    assign bus.instruction = bus.inst_valid ? head.inst : '0;
    assign bus.pc          = bus.inst_valid ? head.pc   : '0;
    assign pop             = bus.inst_valid && !bus.fetch_stall && !bus.branch_taken;

    assign target_pc       = {bus.branch_target[ADDR_WIDTH-1:2], 2'b00};
    assign push_entry.inst = bus.imem_resp_data;
    assign push_entry.pc   = resp_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (bus.branch_taken) begin
            // Everything still in flight belongs to the old path and must be discarded on return.
            fetch_pc    <= target_pc;
            resp_pc     <= target_pc;
            outstanding <= outstanding - CNT_W'(resp_fire);
            drop_cnt    <= outstanding - CNT_W'(resp_fire);
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + ADDR_WIDTH'(INST_BYTES);
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(resp_fire);
            if (resp_fire) begin
                if (drop_cnt != '0) drop_cnt <= drop_cnt - CNT_W'(1);
                else                resp_pc  <= resp_pc + ADDR_WIDTH'(INST_BYTES);
            end
        end
    end

    ooo_sync_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_entry),
        .pop      (pop),
        .flush    (bus.branch_taken),
        .count    (count),
        .head     (head),
        .full     (full),
        .empty    (empty)
    );

endmodule
